// File: rtl/push_sequencer_if.sv
// Control, particle-memory read port and full_pusher feed of the push sequencer.
// master = sequencer side, slave = surrounding datapath/testbench side.
interface push_sequencer_if #(
    parameter int PWIDTH = 64,
    parameter int AWIDTH = 16
);
    logic                  start;
    logic [31:0]           num_particles;
    logic                  ui_valid;
    logic                  busy;
    logic                  step_done;
    logic                  pmem_ren;
    logic [AWIDTH-1:0]     pmem_raddr;
    logic [2*PWIDTH-1:0]   pmem_rdata;
    logic                  push_valid;
    logic                  push_noop;
    logic [2*PWIDTH-1:0]   push_particle;
    logic                  push_done;

    modport master (
        input  start, num_particles, ui_valid, pmem_rdata, push_done,
        output busy, step_done, pmem_ren, pmem_raddr, push_valid, push_noop, push_particle
    );

    modport slave (
        output start, num_particles, ui_valid, pmem_rdata, push_done,
        input  busy, step_done, pmem_ren, pmem_raddr, push_valid, push_noop, push_particle
    );
endinterface

// File: rtl/push_sequencer.sv
// Streams ceil(N/2) particle pairs from memory into full_pusher, then waits for its done.
// Latency: first push RD_LAT cycles after first read; step_done the cycle after an accepted push_done.
// Backpressure: none, one pair per cycle; optional step_cycles output under PUSH_SEQ_CYCLE_COUNT_EN.
module push_sequencer #(
    parameter int PWIDTH = 64,
    parameter int AWIDTH = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    push_sequencer_if.master  bus
`ifdef PUSH_SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]       step_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [AWIDTH-1:0]     addr_q, addr_d;
    logic [31:0]           last_idx_q, last_idx_d;
    logic                  odd_q, odd_d;
    logic                  last_pushed_q, last_pushed_d;
    logic [RD_LAT-1:0]     ren_dly_q, ren_dly_d;
    logic [RD_LAT-1:0]     last_dly_q, last_dly_d;
    logic [2*PWIDTH-1:0]   hold_q, hold_d;

    logic [32:0]           n_plus1;
    logic [31:0]           pairs;
    logic                  accept;
    logic                  issue_last;
    logic                  dly_vld;
    logic                  dly_last;

    // 33-bit sum so N = 2^32-1 still yields 2^31 pairs
    assign n_plus1    = {1'b0, bus.num_particles} + 33'd1;
    assign pairs      = 32'(n_plus1 >> 1);
    assign accept     = (state_q == S_IDLE) && bus.start && !bus.ui_valid;
    assign issue_last = (state_q == S_ISSUE) && (32'(addr_q) == last_idx_q);
    assign dly_vld    = ren_dly_q[RD_LAT-1];
    assign dly_last   = last_dly_q[RD_LAT-1];

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        last_idx_d    = last_idx_q;
        odd_d         = odd_q;
        last_pushed_d = last_pushed_q;

        if (dly_vld && dly_last) begin
            last_pushed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d        = '0;
                    last_idx_d    = pairs - 32'd1;
                    odd_d         = bus.num_particles[0];
                    last_pushed_d = 1'b0;
                    state_d       = (bus.num_particles == 32'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_last) begin
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d  = addr_q + AWIDTH'(1);
                end
            end
            S_DRAIN: begin
                // a done seen before the last pair reached the pusher belongs to nothing
                if (bus.push_done && last_pushed_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ren_dly_d     = '0;
        last_dly_d    = '0;
        ren_dly_d[0]  = (state_q == S_ISSUE);
        last_dly_d[0] = issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            ren_dly_d[i]  = ren_dly_q[i-1];
            last_dly_d[i] = last_dly_q[i-1];
        end
    end

    assign bus.busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign bus.step_done     = (state_q == S_DONE);
    assign bus.pmem_ren      = (state_q == S_ISSUE);
    assign bus.pmem_raddr    = addr_q;
    assign bus.push_valid    = dly_vld;
    assign bus.push_noop     = dly_vld && dly_last && odd_q;
    assign bus.push_particle = dly_vld ? bus.pmem_rdata : hold_q;
    assign hold_d            = bus.push_particle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            last_idx_q    <= '0;
            odd_q         <= 1'b0;
            last_pushed_q <= 1'b0;
            ren_dly_q     <= '0;
            last_dly_q    <= '0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            last_idx_q    <= last_idx_d;
            odd_q         <= odd_d;
            last_pushed_q <= last_pushed_d;
            ren_dly_q     <= ren_dly_d;
            last_dly_q    <= last_dly_d;
            hold_q        <= hold_d;
        end
    end

`ifdef PUSH_SEQ_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    // the accepting cycle counts as 1; every non-idle cycle through DONE adds one
    always_comb begin
        cyc_d = cyc_q;
        if (accept) begin
            cyc_d = 32'd1;
        end else if ((state_q != S_IDLE) && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign step_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_push_sequencer.sv
// Directed bench for push_sequencer: pipelined particle-memory model, cycle-stamped output log.
module tb_push_sequencer;
    localparam int PW = 64;
    localparam int AW = 16;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    push_sequencer_if #(.PWIDTH(PW), .AWIDTH(AW)) bus ();

`ifdef PUSH_SEQ_CYCLE_COUNT_EN
    logic [31:0] step_cycles;
`endif

    push_sequencer #(.PWIDTH(PW), .AWIDTH(AW), .RD_LAT(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PUSH_SEQ_CYCLE_COUNT_EN
        ,
        .step_cycles (step_cycles)
`endif
    );

    function automatic logic [127:0] pair_data(input int a);
        return {64'hC0DE_0000_0000_0000 | 64'(2 * a + 1), 64'hBEEF_0000_0000_0000 | 64'(2 * a)};
    endfunction

    // two-stage memory read pipeline; junk when not read so hold behaviour is visible
    logic [127:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= bus.pmem_ren ? pair_data(int'(bus.pmem_raddr)) : {128{1'b1}};
        rd2 <= rd1;
    end
    assign bus.pmem_rdata = rd2;

    int cyc = 0;
    int ren_cyc[$];
    int ren_addr[$];
    int pv_cyc[$];
    bit pv_noop[$];
    logic [127:0] pv_dat[$];
    int sd_cyc[$];
    int busy_cnt = 0;
    int viol = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.pmem_ren) begin
            ren_cyc.push_back(cyc);
            ren_addr.push_back(int'(bus.pmem_raddr));
        end
        if (bus.push_valid) begin
            pv_cyc.push_back(cyc);
            pv_noop.push_back(bus.push_noop);
            pv_dat.push_back(bus.push_particle);
        end
        if (bus.step_done) sd_cyc.push_back(cyc);
        if (bus.busy) busy_cnt++;
        if (bus.busy && bus.ui_valid) viol++;
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        ren_cyc.delete();
        ren_addr.delete();
        pv_cyc.delete();
        pv_noop.delete();
        pv_dat.delete();
        sd_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic run_step(input string pfx, input int n, input bit early);
        int s, pairs, d, sd_exp, bad;
        clear_logs();
        pairs = (n + 1) / 2;
        bus.start = 1'b1;
        bus.num_particles = n;
        s = cyc + 1;
        tick();
        bus.start = 1'b0;
        d = s + pairs + 2;
        sd_exp = (n > 0) ? d + 1 : s;
        for (int i = 0; i < pairs + 12; i++) begin
            bus.push_done = ((n > 0) && (cyc == d)) ||
                            (early && ((cyc == s + 1) || (cyc == s + pairs)));
            tick();
        end
        bus.push_done = 1'b0;

        chk({pfx, "_ren_cnt"}, ren_cyc.size(), pairs);
        bad = 0;
        foreach (ren_cyc[i]) if (ren_addr[i] != i || ren_cyc[i] != s + i) bad++;
        chk({pfx, "_ren_seq_errs"}, bad, 0);

        chk({pfx, "_pv_cnt"}, pv_cyc.size(), pairs);
        bad = 0;
        foreach (pv_cyc[i])
            if (pv_cyc[i] != s + RL + i || pv_dat[i] !== pair_data(i) ||
                pv_noop[i] != ((i == pairs - 1) && n[0])) bad++;
        chk({pfx, "_pv_seq_errs"}, bad, 0);

        chk({pfx, "_sd_cnt"}, sd_cyc.size(), 1);
        chk({pfx, "_sd_cyc"}, (sd_cyc.size() > 0) ? sd_cyc[0] : -1, sd_exp);
        chk({pfx, "_busy_cycles"}, busy_cnt, (n > 0) ? pairs + 3 : 0);
        if (n > 0) chk({pfx, "_hold"}, bus.push_particle, pair_data(pairs - 1));
`ifdef PUSH_SEQ_CYCLE_COUNT_EN
        chk({pfx, "_step_cycles"}, step_cycles, sd_exp - s + 2);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.start = 1'b0;
        bus.num_particles = '0;
        bus.ui_valid = 1'b0;
        bus.push_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_busy", bus.busy, 0);
        chk("rst_step_done", bus.step_done, 0);
        chk("rst_pmem_ren", bus.pmem_ren, 0);
        chk("rst_pmem_raddr", bus.pmem_raddr, 0);
        chk("rst_push_valid", bus.push_valid, 0);
        chk("rst_push_noop", bus.push_noop, 0);
        chk("rst_push_particle", bus.push_particle, 0);
`ifdef PUSH_SEQ_CYCLE_COUNT_EN
        chk("rst_step_cycles", step_cycles, 0);
`endif

        run_step("n8", 8, 1'b0);
        run_step("n5", 5, 1'b0);
        run_step("n0", 0, 1'b0);

        // start while UART owns port A is dropped
        clear_logs();
        bus.ui_valid = 1'b1;
        bus.start = 1'b1;
        bus.num_particles = 4;
        tick();
        bus.start = 1'b0;
        tick();
        chk("ui_busy", bus.busy, 0);
        tick();
        chk("ui_ren_cnt", ren_cyc.size(), 0);
        chk("ui_sd_cnt", sd_cyc.size(), 0);
        bus.ui_valid = 1'b0;
        tick();
        run_step("ui_then_n2", 2, 1'b0);

        run_step("early", 6, 1'b1);

        // reset in the middle of the issue phase
        clear_logs();
        bus.start = 1'b1;
        bus.num_particles = 100;
        s = cyc + 1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 40 && cyc < s + 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_pmem_ren", bus.pmem_ren, 0);
        chk("midrst_pmem_raddr", bus.pmem_raddr, 0);
        chk("midrst_push_valid", bus.push_valid, 0);
        chk("midrst_push_particle", bus.push_particle, 0);
        chk("midrst_last_addr", (ren_addr.size() > 0) ? ren_addr[$] : -1, 10);
`ifdef PUSH_SEQ_CYCLE_COUNT_EN
        chk("midrst_step_cycles", step_cycles, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            bus.push_done = cyc[0];
            tick();
        end
        bus.push_done = 1'b0;
        chk("midrst_ren_cnt", ren_cyc.size(), 11);
        chk("midrst_pv_cnt", pv_cyc.size(), 9);
        chk("midrst_sd_cnt", sd_cyc.size(), 0);
        chk("midrst_busy_after", bus.busy, 0);

        chk("ui_valid_while_busy", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
